// File: rtl/checker_pkg.sv
// Shared definitions for the gate truth-table checker.
//   state_t      : session FSM states
//   TT_*2        : 2-input gate truth tables, bit k = output for input vector k
package checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count up by one, holds at all-ones
//   q          : count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/truth_table_checker.sv
// Response checker for a combinational gate. Each valid cycle in a session
// compares dut_o against TRUTH[in_vec], counts vectors and errors, records
// input coverage and the first failing vector, and reports a verdict.
//   clk, rst_n          : clock, async active-low reset
//   start, stop         : session control pulses
//   in_valid, in_vec    : sample strobe and the gate's input vector
//   dut_o               : gate output under test
//   busy, done, pass    : session status and verdict (pass valid with done)
//   mismatch            : one-cycle pulse after each failing sample
//   vec_cnt, err_cnt    : saturating vector / error counts
//   first_fail_vec/_idx : input vector and vec_cnt of the first failure
//   coverage            : bit k set once in_vec == k was sampled
module truth_table_checker
    import checker_pkg::*;
#(
    parameter int                  N_IN  = 2,
    parameter logic [2**N_IN-1:0]  TRUTH = TT_OR2,
    parameter int                  CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 in_valid,
    input  logic [N_IN-1:0]      in_vec,
    input  logic                 dut_o,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     vec_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [N_IN-1:0]      first_fail_vec,
    output logic [CNT_W-1:0]     first_fail_idx,
    output logic [2**N_IN-1:0]   coverage
);

    state_t state, state_nxt;

    logic sample;
    logic fail;
    logic clr;

    assign sample = (state == RUN) && in_valid;
    assign fail   = sample && (dut_o != TRUTH[in_vec]);
    // start only opens a new session outside RUN; inside RUN it is ignored
    assign clr    = (state != RUN) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (stop)  state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_vec_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (sample),
        .q     (vec_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (fail),
        .q     (err_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch       <= 1'b0;
            coverage       <= '0;
            first_fail_vec <= '0;
            first_fail_idx <= '0;
        end else begin
            mismatch <= fail;
            if (clr) begin
                coverage       <= '0;
                first_fail_vec <= '0;
                first_fail_idx <= '0;
            end else begin
                if (sample)
                    coverage[in_vec] <= 1'b1;
                // err_cnt is still zero only before the first failure lands;
                // saturation never brings it back to zero
                if (fail && (err_cnt == '0)) begin
                    first_fail_vec <= in_vec;
                    first_fail_idx <= vec_cnt;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0) && (&coverage);

endmodule
